// File: rtl/qspi_flash_responder_pkg.sv
// Shared constants for the QSPI flash responder: opcodes, FSM state codes
// and phase lengths.
package qspi_resp_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_QREAD = 8'hEB;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_WRSR   = 3'd2;
  localparam state_t ST_ADDR   = 3'd3;
  localparam state_t ST_MODE   = 3'd4;
  localparam state_t ST_DUMMY  = 3'd5;
  localparam state_t ST_DATA   = 3'd6;
  localparam state_t ST_IGNORE = 3'd7;

  localparam int CMD_BITS  = 8;
  localparam int WRSR_BITS = 16;
  localparam int ADDR_NIBS = 6;
  localparam int MODE_NIBS = 2;

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Flash link plus byte-wide memory port seen by the responder.
interface qspi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              sck;
  logic              csn;
  logic [3:0]        io_in;
  logic [3:0]        io_out;
  logic [3:0]        io_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              qe;
  logic              cont_mode;

  modport slave (
    input  sck, csn, io_in, mem_rdata,
    output io_out, io_oe, mem_addr, mem_rd, qe, cont_mode
  );

  modport master (
    output sck, csn, io_in, mem_rdata,
    input  io_out, io_oe, mem_addr, mem_rd, qe, cont_mode
  );
endinterface

// File: rtl/qspi_flash_responder_sync.sv
// Two-flop synchronizers for the flash pins and SCK edge pulses in the HCLK domain.
module qspi_resp_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sck_i,
  input  logic       csn_i,
  input  logic [3:0] io_i,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       csn_o,
  output logic [3:0] io_o
);
  logic [1:0] sck_q;
  logic [1:0] csn_q;
  logic [3:0] io_meta_q;
  logic [3:0] io_q;
  logic       sck_prev_q;

  // csn resets high so a reset never looks like the start of a transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q      <= 2'b00;
      csn_q      <= 2'b11;
      io_meta_q  <= 4'h0;
      io_q       <= 4'h0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[0], sck_i};
      csn_q      <= {csn_q[0], csn_i};
      io_meta_q  <= io_i;
      io_q       <= io_meta_q;
      sck_prev_q <= sck_q[1];
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[1] & sck_prev_q;
  assign csn_o      = csn_q[1];
  assign io_o       = io_q;
endmodule

// File: rtl/qspi_flash_responder.sv
// Flash-side end of the quad XIP link: WREN, WRSR (QE bit) and 0xEB quad read
// with continuous-read mode, served from a byte-wide synchronous memory.
module qspi_flash_responder
  import qspi_resp_pkg::*;
#(
  parameter int         ADDR_W     = 24,
  parameter logic       QE_RESET   = 1'b0,
  parameter int         DUMMY_CLKS = 4,
  parameter logic [3:0] CONT_NIB   = 4'hA
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  qspi_flash_responder_if.slave bus
);
  logic       sck_rise, sck_fall, csn_s;
  logic [3:0] io_s;

  qspi_resp_sync u_sync (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .sck_i      (bus.sck),
    .csn_i      (bus.csn),
    .io_i       (bus.io_in),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .csn_o      (csn_s),
    .io_o       (io_s)
  );

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [19:0]       sh_q, sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [7:0]        cur_q, cur_d, nxt_q, nxt_d;
  logic              lo_q, lo_d;
  logic              wel_q, wel_d, qe_q, qe_d, cont_q, cont_d;
  logic              rd_q, rd_d, pend_q;
  logic [3:0]        out_q, out_d, oe_q, oe_d;
  logic [19:0]       sh_bit;
  logic [23:0]       sh_nib;

  assign sh_bit = {sh_q[18:0], io_s[0]};
  assign sh_nib = {sh_q[19:0], io_s};

  // cur_q is the byte on the wire; nxt_q receives every memory read and is
  // handed to cur_q once the low nibble of the current byte goes out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    maddr_d = maddr_q;
    cur_d   = cur_q;
    nxt_d   = pend_q ? bus.mem_rdata : nxt_q;
    lo_d    = lo_q;
    wel_d   = wel_q;
    qe_d    = qe_q;
    cont_d  = cont_q;
    rd_d    = 1'b0;
    out_d   = out_q;
    oe_d    = oe_q;
    if (csn_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      oe_d    = 4'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = cont_q ? ST_ADDR : ST_CMD;
          cnt_d   = '0;
          lo_d    = 1'b0;
        end
        ST_CMD: if (sck_rise) begin
          sh_d  = sh_bit;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(CMD_BITS - 1)) begin
            cnt_d = '0;
            case (sh_bit[7:0])
              OP_WREN: begin
                wel_d   = 1'b1;
                state_d = ST_IGNORE;
              end
              OP_WRSR:  state_d = wel_q ? ST_WRSR : ST_IGNORE;
              OP_QREAD: state_d = qe_q ? ST_ADDR : ST_IGNORE;
              default:  state_d = ST_IGNORE;
            endcase
          end
        end
        ST_WRSR: if (sck_rise) begin
          sh_d  = sh_bit;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(WRSR_BITS - 1)) begin
            qe_d    = sh_bit[1];
            wel_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_IGNORE;
          end
        end
        ST_ADDR: if (sck_rise) begin
          sh_d  = sh_nib[19:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ADDR_NIBS - 1)) begin
            addr_d  = sh_nib[ADDR_W-1:0];
            maddr_d = sh_nib[ADDR_W-1:0];
            rd_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_MODE;
          end
        end
        ST_MODE: if (sck_rise) begin
          sh_d  = sh_nib[19:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(MODE_NIBS - 1)) begin
            cont_d  = (sh_q[3:0] == CONT_NIB);
            cur_d   = nxt_q;
            cnt_d   = '0;
            state_d = ST_DUMMY;
          end
        end
        ST_DUMMY: if (sck_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd0) begin
            maddr_d = addr_q + 1'b1;
            rd_d    = 1'b1;
          end
          if (cnt_q == 5'(DUMMY_CLKS - 1)) begin
            cnt_d   = '0;
            lo_d    = 1'b0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: if (sck_fall) begin
          oe_d = 4'hF;
          lo_d = ~lo_q;
          if (!lo_q) begin
            out_d   = cur_q[7:4];
            addr_d  = addr_q + 1'b1;
            maddr_d = addr_q + 1'b1;
            rd_d    = 1'b1;
          end else begin
            out_d = cur_q[3:0];
            cur_d = nxt_q;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      maddr_q <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      lo_q    <= 1'b0;
      wel_q   <= 1'b0;
      qe_q    <= QE_RESET;
      cont_q  <= 1'b0;
      rd_q    <= 1'b0;
      pend_q  <= 1'b0;
      out_q   <= 4'h0;
      oe_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      lo_q    <= lo_d;
      wel_q   <= wel_d;
      qe_q    <= qe_d;
      cont_q  <= cont_d;
      rd_q    <= rd_d;
      pend_q  <= rd_q;
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

  assign bus.io_out    = out_q;
  assign bus.io_oe     = oe_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.qe        = qe_q;
  assign bus.cont_mode = cont_q;
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed and randomized transactions against a spec-level model of the
// responder's register bits and the byte stream a quad read must return.
module tb_qspi_flash_responder;
  localparam int ADDR_W = 24;
  localparam int DUMMY  = 4;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  qspi_flash_responder_if #(.ADDR_W(ADDR_W)) bus_if ();

  qspi_flash_responder #(
    .ADDR_W(ADDR_W), .QE_RESET(1'b0), .DUMMY_CLKS(DUMMY), .CONT_NIB(4'hA)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_if)
  );

  logic [7:0]  mem [logic [23:0]];
  logic [23:0] rd_log [$];
  int          oe_cycles = 0;
  int          checks = 0;
  int          passed = 0;
  bit          qe_m, cont_m, wel_m;

  function automatic logic [7:0] memv(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'hC3;
  endfunction

  // synchronous memory: data one HCLK after the strobe
  always @(posedge HCLK) begin
    if (bus_if.mem_rd) begin
      bus_if.mem_rdata <= memv(bus_if.mem_addr);
      rd_log.push_back(bus_if.mem_addr);
    end
  end

  always @(negedge HCLK) if (bus_if.io_oe != 4'h0) oe_cycles <= oe_cycles + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clk_pulse(input logic [3:0] d);
    bus_if.io_in = d;
    repeat (3) @(negedge HCLK);
    bus_if.sck = 1'b1;
    repeat (6) @(negedge HCLK);
    bus_if.sck = 1'b0;
    repeat (3) @(negedge HCLK);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clk_pulse({3'b000, b[i]});
  endtask

  task automatic csn_low();
    @(negedge HCLK);
    bus_if.csn = 1'b0;
    repeat (4) @(negedge HCLK);
  endtask

  task automatic csn_high();
    repeat (4) @(negedge HCLK);
    bus_if.csn = 1'b1;
    repeat (6) @(negedge HCLK);
  endtask

  task automatic cmd1(input logic [7:0] op);
    csn_low(); spi_byte(op); csn_high();
    if (op == 8'h06) wel_m = 1'b1;
    $display("cmd op=%02h qe=%0b", op, bus_if.qe);
  endtask

  task automatic wrsr(input logic [7:0] st, input logic [7:0] cfg);
    csn_low(); spi_byte(8'h01); spi_byte(st); spi_byte(cfg); csn_high();
    if (wel_m) begin
      qe_m  = cfg[1];
      wel_m = 1'b0;
    end
    chk("wrsr_qe", bus_if.qe, qe_m);
    $display("wrsr cfg=%02h qe=%0b", cfg, bus_if.qe);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [7:0] mode, input int n);
    int          base, oe0;
    logic [23:0] uniq [$];
    logic [7:0]  b;
    base = rd_log.size();
    csn_low();
    oe0 = oe_cycles;
    if (!cont_m) spi_byte(8'hEB);
    for (int i = 0; i < 6; i++) clk_pulse(a[23-4*i -: 4]);
    clk_pulse(mode[7:4]);
    clk_pulse(mode[3:0]);
    for (int d = 0; d < DUMMY - 1; d++) clk_pulse(4'h0);
    chk("pre_data_oe", oe_cycles - oe0, 0);
    clk_pulse(4'h0);
    for (int k = 0; k < 2 * n; k++) begin
      repeat (3) @(negedge HCLK);
      b = memv(a + 24'(k / 2));
      chk("data_oe", bus_if.io_oe, 4'hF);
      chk("data_nib", bus_if.io_out, (k % 2 == 0) ? b[7:4] : b[3:0]);
      clk_pulse(4'h0);
    end
    csn_high();
    chk("idle_oe", bus_if.io_oe, 4'h0);
    cont_m = (mode[7:4] == 4'hA);
    chk("cont_mode", bus_if.cont_mode, cont_m);
    for (int i = base; i < rd_log.size(); i++)
      if (uniq.size() == 0 || uniq[$] != rd_log[i]) uniq.push_back(rd_log[i]);
    for (int k = 0; k < n; k++)
      chk("rd_addr", (k < uniq.size()) ? {8'h00, uniq[k]} : 32'hFFFF_FFFF, {8'h00, a + 24'(k)});
    $display("read addr=%06h mode=%02h bytes=%0d cont=%0b", a, mode, n, bus_if.cont_mode);
  endtask

  initial begin
    logic [23:0] a;
    logic [7:0]  md;
    int          n, snap_oe, snap_rd;
    bus_if.sck   = 1'b0;
    bus_if.csn   = 1'b1;
    bus_if.io_in = 4'h0;
    mem[24'h000010] = 8'h78; mem[24'h000011] = 8'h56;
    mem[24'h000012] = 8'h34; mem[24'h000013] = 8'h12;
    qe_m = 1'b0; cont_m = 1'b0; wel_m = 1'b0;

    repeat (3) @(negedge HCLK);
    chk("rst_io_oe", bus_if.io_oe, 4'h0);
    chk("rst_io_out", bus_if.io_out, 4'h0);
    chk("rst_mem_rd", bus_if.mem_rd, 1'b0);
    chk("rst_mem_addr", bus_if.mem_addr, 24'h0);
    chk("rst_qe", bus_if.qe, 1'b0);
    chk("rst_cont", bus_if.cont_mode, 1'b0);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);
    $display("reset released");

    // WRSR without WREN must not take effect
    wrsr(8'h00, 8'h02);

    // quad read while QE is clear is ignored entirely
    snap_oe = oe_cycles;
    snap_rd = rd_log.size();
    csn_low();
    spi_byte(8'hEB);
    for (int i = 0; i < 6 + 2 + DUMMY + 4; i++) clk_pulse(4'hA);
    csn_high();
    chk("guard_oe", oe_cycles - snap_oe, 0);
    chk("guard_rd", rd_log.size() - snap_rd, 0);
    chk("guard_cont", bus_if.cont_mode, 1'b0);
    $display("guarded quad read with qe=0");

    cmd1(8'h06);
    wrsr(8'h00, 8'h02);
    // WEL consumed by the previous WRSR
    wrsr(8'h00, 8'h00);

    do_read(24'h000010, 8'hA5, 4);
    do_read(24'h000020, 8'hFF, 2);
    do_read(24'($urandom), 8'h00, 3);

    // abort after three address nibbles
    snap_oe = oe_cycles;
    csn_low();
    spi_byte(8'hEB);
    for (int i = 0; i < 3; i++) clk_pulse(4'h5);
    csn_high();
    chk("abort_oe", oe_cycles - snap_oe, 0);
    $display("aborted read after 3 address nibbles");
    do_read(24'h000011, 8'h00, 2);

    do_read(24'hFFFFFF, 8'h00, 2);

    for (int t = 0; t < 6; t++) begin
      a  = 24'($urandom);
      n  = $urandom_range(1, 4);
      md = ($urandom_range(0, 1) == 1) ? {4'hA, 4'($urandom)} : 8'($urandom);
      for (int j = 0; j < n; j++) mem[a + 24'(j)] = 8'($urandom);
      do_read(a, md, n);
    end
    if (cont_m) do_read(24'h000100, 8'h00, 1);

    // reset in the middle of a continuous-mode read
    csn_low();
    spi_byte(8'hEB);
    for (int i = 0; i < 6; i++) clk_pulse(4'h0);
    clk_pulse(4'hA);
    clk_pulse(4'h0);
    for (int d = 0; d < DUMMY; d++) clk_pulse(4'h0);
    for (int k = 0; k < 3; k++) clk_pulse(4'h0);
    chk("pre_rst_cont", bus_if.cont_mode, 1'b1);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("midrst_io_oe", bus_if.io_oe, 4'h0);
    chk("midrst_mem_rd", bus_if.mem_rd, 1'b0);
    chk("midrst_qe", bus_if.qe, 1'b0);
    chk("midrst_cont", bus_if.cont_mode, 1'b0);
    bus_if.csn = 1'b1;
    bus_if.sck = 1'b0;
    repeat (4) @(negedge HCLK);
    HRESETn = 1'b1;
    qe_m = 1'b0; cont_m = 1'b0; wel_m = 1'b0;
    repeat (4) @(negedge HCLK);
    $display("reset during data phase");

    // after reset the first transaction must be opcode-decoded
    cmd1(8'h06);
    wrsr(8'h00, 8'h02);
    do_read(24'h000010, 8'h00, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
